// File: rtl/time_ascii_reporter.sv
// rtl/time_ascii_reporter.sv - formats a 24-bit time snapshot as "HH:MM:SS.CC" (+ CR LF) into a TX FIFO
// Snapshot is taken on acceptance; bytes stream out one per non-full cycle.
module time_ascii_reporter #(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_send,
  input  logic [23:0] i_time,
  input  logic        i_full,
  output logic        o_push,
  output logic [7:0]  o_push_data,
  output logic        o_busy
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] LAST = SEND_CRLF ? 4'd12 : 4'd10;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [23:0] snap;
  logic        busy;
  logic        load;
  logic [15:0] hh, mm, ss, cc;
  logic [7:0]  ch;

  // Repeated subtraction of ten; values of 100 and above saturate to "99".
  function automatic logic [15:0] two_digits(input logic [6:0] v);
    logic [3:0] t;
    logic [6:0] r;
    if (v >= 7'd100) return {8'h39, 8'h39};
    t = 4'd0;
    r = v;
    for (int k = 0; k < 9; k++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {8'h30 + {4'b0000, t}, 8'h30 + {1'b0, r}};
  endfunction

  assign hh = two_digits({2'b00, snap[23:19]});
  assign mm = two_digits({1'b0, snap[18:13]});
  assign ss = two_digits({1'b0, snap[12:7]});
  assign cc = two_digits(snap[6:0]);

  always_comb begin
    ch = 8'h00;
    case (idx)
      4'd0:  ch = hh[15:8];
      4'd1:  ch = hh[7:0];
      4'd2:  ch = 8'h3A;
      4'd3:  ch = mm[15:8];
      4'd4:  ch = mm[7:0];
      4'd5:  ch = 8'h3A;
      4'd6:  ch = ss[15:8];
      4'd7:  ch = ss[7:0];
      4'd8:  ch = 8'h2E;
      4'd9:  ch = cc[15:8];
      4'd10: ch = cc[7:0];
      4'd11: ch = 8'h0D;
      4'd12: ch = 8'h0A;
      default: ch = 8'h00;
    endcase
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    load        = 1'b0;
    o_push      = 1'b0;
    o_push_data = 8'h00;
    case (state)
      IDLE: begin
        if (i_send) begin
          state_n = SEND;
          idx_n   = 4'd0;
          load    = 1'b1;
        end
      end
      SEND: begin
        o_push      = ~i_full;
        o_push_data = ch;
        if (!i_full) begin
          if (idx == LAST) state_n = IDLE;
          else             idx_n   = idx + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 4'd0;
      snap  <= 24'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load) snap <= i_time;
      busy  <= (state_n == SEND);
    end
  end

  assign o_busy = busy;

endmodule
